// File: rtl/bird_kinematics_pkg.sv
// rtl/bird_kinematics_pkg.sv - shared state encoding and playfield defaults for the bird physics block
package bird_kinematics_pkg;

  // One-hot flight states; any other pattern is treated as corrupt and recovers to INITIAL.
  localparam logic [3:0] ST_INITIAL = 4'b0001;
  localparam logic [3:0] ST_FLIGHT  = 4'b0010;
  localparam logic [3:0] ST_DYING   = 4'b0100;
  localparam logic [3:0] ST_STOP    = 4'b1000;

  // Playfield geometry defaults, in whole pixels.
  localparam int SCREEN_H_DEF = 480;
  localparam int BIRD_W_DEF   = 20;
  localparam int BIRD_H_DEF   = 20;
  localparam int BIRD_X_DEF   = 300;
  localparam int START_Y_DEF  = 240;

  // Sub-pixel fraction bits used for position and velocity.
  localparam int FRAC_DEF = 4;

endpackage

// File: rtl/bird_kinematics_btn_edge_latch.sv
// rtl/bird_kinematics_btn_edge_latch.sv - flap button rising-edge detect with pending-request latch
module btn_edge_latch
  import bird_kinematics_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_arm,
  input  logic i_clr,
  output logic o_pending
);

  logic r_btn_q;
  logic r_btn_qq;
  logic r_pend;
  logic w_edge;

  // The raw button is registered once before the edge compare so the edge is glitch-free.
  assign w_edge    = r_btn_q & ~r_btn_qq;
  assign o_pending = r_pend;

  // Button history plus the latch; an edge arriving on a clearing cycle still arms the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_q  <= 1'b0;
      r_btn_qq <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_btn_q  <= i_btn;
      r_btn_qq <= r_btn_q;
      r_pend   <= (r_pend & ~i_clr) | (w_edge & i_arm);
    end
  end

endmodule

// File: rtl/bird_kinematics.sv
// rtl/bird_kinematics.sv - flappy-bird vertical kinematics: flap, gravity, ceiling/floor clamps, life-cycle FSM
module bird_kinematics
  import bird_kinematics_pkg::*;
#(
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int BIRD_W   = BIRD_W_DEF,
  parameter int BIRD_H   = BIRD_H_DEF,
  parameter int BIRD_X   = BIRD_X_DEF,
  parameter int START_Y  = START_Y_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int JUMP_VEL = 128,
  parameter int GRAVITY  = 8,
  parameter int TERM_VEL = 160
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     Start,
  input  logic                     Ack,
  input  logic                     Stop,
  input  logic                     BtnPress,
  input  logic                     FrameTick,
  output logic [9:0]               Bird_X_L,
  output logic [9:0]               Bird_X_R,
  output logic [9:0]               Bird_Y_T,
  output logic [9:0]               Bird_Y_B,
  output logic signed [10+FRAC-1:0] Velocity,
  output logic                     HitCeiling,
  output logic                     HitFloor,
  output logic                     q_Initial,
  output logic                     q_Flight,
  output logic                     q_Dying,
  output logic                     q_Stop
);

  // Position/velocity width, and the widened width with two signed guard bits for the update.
  localparam int YW = 10 + FRAC;
  localparam int SW = YW + 2;

  localparam logic [YW-1:0]        C_Y_START = YW'(START_Y << FRAC);
  localparam logic signed [SW-1:0] C_Y_FLOOR = SW'((SCREEN_H - BIRD_H) << FRAC);
  localparam logic signed [YW-1:0] C_JUMP    = YW'(-JUMP_VEL);
  localparam logic signed [SW-1:0] C_GRAV    = SW'(GRAVITY);
  localparam logic signed [SW-1:0] C_TERM_S  = SW'(TERM_VEL);
  localparam logic signed [YW-1:0] C_TERM    = YW'(TERM_VEL);

  logic [3:0]              r_state;
  logic [YW-1:0]           r_y;
  logic signed [YW-1:0]    r_vel;
  logic                    r_hit_c;
  logic                    r_hit_f;

  logic                    w_in_flight;
  logic                    w_pending;
  logic                    w_flap;
  logic signed [SW-1:0]    w_vel_grav;
  logic signed [YW-1:0]    w_vel_new;
  logic signed [SW-1:0]    w_y_new;

  assign w_in_flight = (r_state == ST_FLIGHT);

  // A flap is only honoured in FLIGHT and never on the cycle the bird is killed.
  assign w_flap = w_in_flight & w_pending & ~Stop;

  btn_edge_latch u_btn (
    .clk       (Clk),
    .rst       (reset),
    .i_btn     (BtnPress),
    .i_arm     (w_in_flight & ~Stop),
    .i_clr     (~w_in_flight | FrameTick | Stop),
    .o_pending (w_pending)
  );

  // Candidate velocity and position for this tick (semi-implicit Euler: new velocity moves the bird).
  always_comb begin
    w_vel_grav = {{2{r_vel[YW-1]}}, r_vel} + C_GRAV;
    w_vel_new  = '0;
    if (w_flap) begin
      w_vel_new = C_JUMP;
    end else if (w_vel_grav > C_TERM_S) begin
      w_vel_new = C_TERM;
    end else begin
      w_vel_new = w_vel_grav[YW-1:0];
    end
    w_y_new = $signed({2'b00, r_y}) + {{2{w_vel_new[YW-1]}}, w_vel_new};
  end

  // State machine, physics registers and one-cycle collision pulses.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INITIAL;
      r_y     <= C_Y_START;
      r_vel   <= '0;
      r_hit_c <= 1'b0;
      r_hit_f <= 1'b0;
    end else begin
      r_hit_c <= 1'b0;
      r_hit_f <= 1'b0;
      case (r_state)
        ST_INITIAL: begin
          r_y   <= C_Y_START;
          r_vel <= '0;
          if (Start) r_state <= ST_FLIGHT;
        end
        ST_FLIGHT, ST_DYING: begin
          if (Stop && w_in_flight) r_state <= ST_DYING;
          if (FrameTick) begin
            if (w_y_new[SW-1]) begin
              r_y     <= '0;
              r_vel   <= '0;
              r_hit_c <= 1'b1;
            end else if (w_y_new >= C_Y_FLOOR) begin
              r_y     <= C_Y_FLOOR[YW-1:0];
              r_vel   <= '0;
              r_hit_f <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_y   <= w_y_new[YW-1:0];
              r_vel <= w_vel_new;
            end
          end
        end
        ST_STOP: begin
          if (Ack) begin
            r_state <= ST_INITIAL;
            r_y     <= C_Y_START;
            r_vel   <= '0;
          end
        end
        default: begin
          r_state <= ST_INITIAL;
          r_y     <= C_Y_START;
          r_vel   <= '0;
        end
      endcase
    end
  end

  assign Bird_X_L   = 10'(BIRD_X);
  assign Bird_X_R   = 10'(BIRD_X + BIRD_W);
  assign Bird_Y_T   = r_y[YW-1:FRAC];
  assign Bird_Y_B   = r_y[YW-1:FRAC] + 10'(BIRD_H);
  assign Velocity   = r_vel;
  assign HitCeiling = r_hit_c;
  assign HitFloor   = r_hit_f;
  assign q_Initial  = r_state[0];
  assign q_Flight   = r_state[1];
  assign q_Dying    = r_state[2];
  assign q_Stop     = r_state[3];

endmodule

// File: tb/tb_bird_kinematics.sv
// tb/tb_bird_kinematics.sv - self-checking bench for bird_kinematics against a pixel-arithmetic reference model
module tb_bird_kinematics;

  logic Clk = 1'b0;
  logic reset, Start, Ack, Stop, BtnPress, FrameTick;
  logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
  logic signed [13:0] Velocity;
  logic HitCeiling, HitFloor, q_Initial, q_Flight, q_Dying, q_Stop;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position in 1/16 px, velocity in 1/16 px per frame, state 0..3.
  int m_y, m_vel, m_state;
  bit m_pend, m_hc, m_hf;
  int old_vel;

  bird_kinematics dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Stop(Stop),
    .BtnPress(BtnPress), .FrameTick(FrameTick),
    .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
    .Velocity(Velocity), .HitCeiling(HitCeiling), .HitFloor(HitFloor),
    .q_Initial(q_Initial), .q_Flight(q_Flight), .q_Dying(q_Dying), .q_Stop(q_Stop)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".xl"}, int'(Bird_X_L), 300);
    chk({tag, ".xr"}, int'(Bird_X_R), 320);
    chk({tag, ".yt"}, int'(Bird_Y_T), m_y / 16);
    chk({tag, ".yb"}, int'(Bird_Y_B), m_y / 16 + 20);
    chk({tag, ".vel"}, int'(Velocity), m_vel);
    chk({tag, ".hc"}, int'(HitCeiling), int'(m_hc));
    chk({tag, ".hf"}, int'(HitFloor), int'(m_hf));
    chk({tag, ".qi"}, int'(q_Initial), int'(m_state == 0));
    chk({tag, ".qf"}, int'(q_Flight), int'(m_state == 1));
    chk({tag, ".qd"}, int'(q_Dying), int'(m_state == 2));
    chk({tag, ".qs"}, int'(q_Stop), int'(m_state == 3));
  endtask

  function automatic void model_reset();
    m_state = 0; m_y = 240 * 16; m_vel = 0; m_pend = 0; m_hc = 0; m_hf = 0;
  endfunction

  // One clock of the game rules, written directly from the behavioural description.
  function automatic void model_cycle(input bit st, input bit ack, input bit stp, input bit tk);
    int prev, nv, ny;
    bit flap;
    prev = m_state;
    m_hc = 0; m_hf = 0;
    if (m_state == 0) begin
      m_y = 3840; m_vel = 0;
      if (st) m_state = 1;
    end else if (m_state == 1 || m_state == 2) begin
      if (tk) begin
        flap = (m_state == 1) && m_pend && !stp;
        nv = flap ? -128 : ((m_vel + 8 > 160) ? 160 : m_vel + 8);
        ny = m_y + nv;
        if (ny < 0) begin
          m_y = 0; m_vel = 0; m_hc = 1;
        end else if (ny >= 460 * 16) begin
          m_y = 460 * 16; m_vel = 0; m_hf = 1; m_state = 3;
        end else begin
          m_y = ny; m_vel = nv;
        end
      end
      if (stp && prev == 1 && m_state != 3) m_state = 2;
    end else begin
      if (ack) begin m_state = 0; m_y = 3840; m_vel = 0; end
    end
    if (tk || stp || prev != 1) m_pend = 0;
  endfunction

  task automatic drive(input bit st, input bit ack, input bit stp, input bit btn, input bit tk);
    @(negedge Clk);
    Start = st; Ack = ack; Stop = stp; BtnPress = btn; FrameTick = tk;
    @(posedge Clk);
    #1;
    Start = 0; Ack = 0; Stop = 0; FrameTick = 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0);
      model_cycle(0, 0, 0, 0);
      check_all(tag);
    end
  endtask

  // A frame: one tick cycle followed by three quiet cycles.
  task automatic tick(input bit stp, input string tag);
    drive(0, 0, stp, 0, 1);
    model_cycle(0, 0, stp, 1);
    check_all(tag);
    idle(3, {tag, ".idle"});
  endtask

  task automatic press(input string tag);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0);
      model_cycle(0, 0, 0, 0);
    end
    if (m_state == 1) m_pend = 1;
    BtnPress = 0;
    idle(2, tag);
  endtask

  task automatic pulse(input bit st, input bit ack, input bit stp, input string tag);
    drive(st, ack, stp, 0, 0);
    model_cycle(st, ack, stp, 0);
    check_all(tag);
  endtask

  initial begin
    reset = 1; Start = 0; Ack = 0; Stop = 0; BtnPress = 0; FrameTick = 0;
    model_reset();
    #1;
    check_all("rst");
    repeat (2) @(negedge Clk);
    reset = 0;
    idle(1, "init");

    // Stray Ack/Stop in INITIAL do nothing.
    pulse(0, 1, 0, "ign_ack");
    pulse(0, 0, 1, "ign_stop");

    // Free fall to the floor.
    pulse(1, 0, 0, "ff_start");
    for (int t = 1; t <= 32; t++) begin
      tick(0, $sformatf("ff_t%0d", t));
      if (t == 20) chk("ff_vel20", int'(Velocity), 160);
    end
    chk("ff_yt", int'(Bird_Y_T), 460);
    chk("ff_stop", int'(q_Stop), 1);
    pulse(1, 0, 0, "stop_ign_start");
    pulse(0, 0, 1, "stop_ign_stop");
    tick(0, "stop_ign_tick");
    pulse(0, 1, 0, "stop_ack");

    // Single flap then gravity.
    pulse(1, 0, 0, "fl_start");
    press("fl_press");
    drive(0, 0, 0, 0, 1);
    model_cycle(0, 0, 0, 1);
    check_all("fl_t1");
    chk("fl_yt1", int'(Bird_Y_T), 232);
    chk("fl_v1", int'(Velocity), -128);
    idle(3, "fl_i1");
    tick(0, "fl_t2");
    chk("fl_yt2", int'(Bird_Y_T), 224);
    chk("fl_v2", int'(Velocity), -120);

    // Several edges between ticks collapse to one flap.
    press("m_p1"); press("m_p2"); press("m_p3");
    tick(0, "m_tick");
    chk("m_vel", int'(Velocity), -128);

    // Stop coinciding with a tick that has a pending flap.
    press("s_press");
    old_vel = m_vel;
    tick(1, "s_tick");
    chk("s_vel", int'(Velocity), old_vel + 8);
    chk("s_dying", int'(q_Dying), 1);
    press("d_press");
    pulse(1, 1, 0, "d_ign");
    for (int i = 0; i < 80 && m_state != 3; i++) tick(0, "d_fall");
    chk("d_floor", int'(q_Stop), 1);
    pulse(0, 1, 0, "d_ack");

    // Flap every frame up to the ceiling.
    pulse(1, 0, 0, "c_start");
    for (int t = 1; t <= 31; t++) begin
      press("c_press");
      drive(0, 0, 0, 0, 1);
      model_cycle(0, 0, 0, 1);
      check_all($sformatf("c_t%0d", t));
      if (t == 30) chk("c_yt30", int'(Bird_Y_T), 0);
      if (t == 31) begin
        chk("c_hc", int'(HitCeiling), 1);
        chk("c_yt31", int'(Bird_Y_T), 0);
        chk("c_v31", int'(Velocity), 0);
      end
      idle(3, "c_idle");
    end

    // Fall past y=300, then reset asynchronously mid-flight.
    for (int i = 0; i < 60 && m_y / 16 < 300; i++) tick(0, "r_fall");
    chk("r_reach", int'(Bird_Y_T >= 10'd300), 1);
    @(negedge Clk);
    #2 reset = 1;
    #1;
    model_reset();
    check_all("r_async");
    @(negedge Clk);
    reset = 0;
    idle(1, "r_after");

    // Randomized play.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 11))
        0, 1, 2: tick(0, "rnd_tick");
        3:       tick($urandom_range(0, 5) == 0, "rnd_tstop");
        4, 5, 6: press("rnd_press");
        7:       idle(1, "rnd_idle");
        8, 9:    pulse(1, 0, 0, "rnd_start");
        10:      pulse(0, 1, 0, "rnd_ack");
        default: pulse(0, 0, ($urandom_range(0, 3) == 0), "rnd_stop");
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
